// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: shares one bitwise logic unit (AND/OR/XOR/NOR) between
// two valid/ready requesters, round-robin on contention, with one registered
// response slot tagged by requester id and a wrapping completion counter.
module logic_unit_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic               prio_q, prio_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic               rsp_id_q, rsp_id_d;
    logic [CNT_W-1:0]   op_count_q, op_count_d;

    logic               grant_c;
    logic               grant_id_c;
    logic [1:0]         sel_op_c;
    logic [WIDTH-1:0]   sel_a_c;
    logic [WIDTH-1:0]   sel_b_c;

    // Bitwise result of one operation; no carry, always exactly WIDTH bits.
    function automatic logic [WIDTH-1:0] logic_op(
        input logic [1:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b);
            default: r = '0;
        endcase
        return r;
    endfunction

    // Grant selection: a lone requester wins, otherwise prio breaks the tie.
    always_comb begin
        grant_c    = 1'b0;
        grant_id_c = 1'b0;
        if (state_q == S_IDLE) begin
            if (req0_valid && (!req1_valid || !prio_q)) begin
                grant_c    = 1'b1;
                grant_id_c = 1'b0;
            end else if (req1_valid) begin
                grant_c    = 1'b1;
                grant_id_c = 1'b1;
            end
        end
        sel_op_c = grant_id_c ? req1_op : req0_op;
        sel_a_c  = grant_id_c ? req1_a  : req0_a;
        sel_b_c  = grant_id_c ? req1_b  : req0_b;
    end

    // Next-state and ready logic for the IDLE/RESP sequencer.
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        op_count_d  = op_count_q;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_c) begin
                    req0_ready  = ~grant_id_c;
                    req1_ready  = grant_id_c;
                    rsp_data_d  = logic_op(sel_op_c, sel_a_c, sel_b_c);
                    rsp_id_d    = grant_id_c;
                    rsp_valid_d = 1'b1;
                    prio_d      = ~grant_id_c;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + CNT_W'(1);
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and response registers; reset drops any held response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            prio_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            op_count_q  <= op_count_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter (WIDTH=32, CNT_W=4 so the counter wrap is reachable).
module tb_logic_unit_arbiter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             req0_valid, req0_ready;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic             req1_valid, req1_ready;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic             rsp_valid, rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_id;
    logic [CNT_W-1:0] op_count;

    int n_cmp;
    int n_err;
    logic [CNT_W-1:0] exp_cnt;

    logic_unit_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One uncontended operation from requester id, consumer always ready.
    task automatic do_op(input logic id, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        @(negedge clk);
        rsp_ready = 1'b1;
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
        #1;
        chk("op_ready0", {31'd0, req0_ready}, {31'd0, ~id});
        chk("op_ready1", {31'd0, req1_ready}, {31'd0, id});
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("op_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("op_rsp_data", rsp_data, exp);
        chk("op_rsp_id", {31'd0, rsp_id}, {31'd0, id});
        @(negedge clk);
        #1;
        exp_cnt = exp_cnt + 4'd1;
        chk("op_rsp_drop", {31'd0, rsp_valid}, 32'd0);
        chk("op_count", {28'd0, op_count}, {28'd0, exp_cnt});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_cnt = '0;
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_op = 2'b00; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = 2'b00; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b0;

        // Reset state
        #1;
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_data", rsp_data, 32'd0);
        chk("rst_id", {31'd0, rsp_id}, 32'd0);
        chk("rst_count", {28'd0, op_count}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_ready0", {31'd0, req0_ready}, 32'd0);
        chk("idle_ready1", {31'd0, req1_ready}, 32'd0);

        // Single requester OR
        do_op(1'b0, 2'b01, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F);

        // All four ops on requester 1
        do_op(1'b1, 2'b00, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000);
        do_op(1'b1, 2'b01, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hFFFF_0F0F);
        do_op(1'b1, 2'b10, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
        do_op(1'b1, 2'b11, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0000_F0F0);

        // Contention: req0 AND, req1 XOR, both held valid for 6 operations
        @(negedge clk);
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 32'hAAAA_5555; req0_b = 32'hFF00_FF00;
        req1_valid = 1'b1; req1_op = 2'b10; req1_a = 32'hAAAA_5555; req1_b = 32'hFF00_FF00;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("cont_ready0", {31'd0, req0_ready}, {31'd0, (i % 2) == 0});
            chk("cont_ready1", {31'd0, req1_ready}, {31'd0, (i % 2) == 1});
            @(negedge clk);
            #1;
            chk("cont_valid", {31'd0, rsp_valid}, 32'd1);
            chk("cont_id", {31'd0, rsp_id}, {31'd0, (i % 2) == 1});
            chk("cont_data", rsp_data, ((i % 2) == 0) ? 32'hAA00_5500 : 32'h55AA_AA55);
            chk("cont_no_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
            @(negedge clk);
            exp_cnt = exp_cnt + 4'd1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("cont_count", {28'd0, op_count}, {28'd0, exp_cnt});

        // Backpressure: XOR held 5 cycles, req1 pending but not served
        @(negedge clk);
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 2'b10; req0_a = 32'h1234_5678; req0_b = 32'hFFFF_0000;
        @(negedge clk);
        req0_valid = 1'b0;
        req0_a = 32'h0; req0_op = 2'b00;
        req1_valid = 1'b1; req1_op = 2'b01; req1_a = 32'h1; req1_b = 32'h2;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_data", rsp_data, 32'hEDCB_5678);
            chk("bp_id", {31'd0, rsp_id}, 32'd0);
            chk("bp_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
            chk("bp_count", {28'd0, op_count}, {28'd0, exp_cnt});
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        req1_valid = 1'b0;
        @(negedge clk);
        #1;
        exp_cnt = exp_cnt + 4'd1;
        chk("bp_release", {31'd0, rsp_valid}, 32'd0);
        chk("bp_count2", {28'd0, op_count}, {28'd0, exp_cnt});

        // rsp_ready high while idle: no effect
        repeat (3) @(negedge clk);
        #1;
        chk("idle_rdy_valid", {31'd0, rsp_valid}, 32'd0);
        chk("idle_rdy_count", {28'd0, op_count}, {28'd0, exp_cnt});

        // Counter wrap: 12 done, 4 more reach 16 -> 0
        do_op(1'b0, 2'b00, 32'hFFFF_FFFF, 32'h8000_0001, 32'h8000_0001);
        do_op(1'b0, 2'b11, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF);
        do_op(1'b0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        do_op(1'b0, 2'b01, 32'h0000_0000, 32'h0000_0001, 32'h0000_0001);
        chk("wrap_count", {28'd0, op_count}, 32'd0);

        // Reset mid-RESP: one op (count 1, prio -> 1), then a held response
        do_op(1'b0, 2'b00, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 32'h0F0F_0F0F);
        @(negedge clk);
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 2'b01; req0_a = 32'h1111_0000; req0_b = 32'h0000_2222;
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        chk("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
        chk("pre_rst_data", rsp_data, 32'h1111_2222);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_data", rsp_data, 32'd0);
        chk("mid_rst_id", {31'd0, rsp_id}, 32'd0);
        chk("mid_rst_count", {28'd0, op_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 32'hFFFF_FFFF; req0_b = 32'h1357_9BDF;
        req1_valid = 1'b1; req1_op = 2'b00; req1_a = 32'hFFFF_FFFF; req1_b = 32'h2468_ACE0;
        #1;
        chk("post_rst_ready0", {31'd0, req0_ready}, 32'd1);
        chk("post_rst_ready1", {31'd0, req1_ready}, 32'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("post_rst_id", {31'd0, rsp_id}, 32'd0);
        chk("post_rst_data", rsp_data, 32'h1357_9BDF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
